alu_op_sequencer: RTL

Initiator-side companion to the generated combinational ALUs. It accepts ALU commands over a valid/ready stream and drives one ALU instance's opcode/input1/input2/shiftValue. After a settle interval it captures the result and flags, then returns them in order through a response FIFO. It also resolves the SGT/SLT compares locally and flags illegal opcodes and divide-by-zero, so downstream logic never consumes undefined ALU output.

---
 rtl/alu_op_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for one combinational ALU: drives operands, waits a settle interval,
// captures result/flags and returns them in order through a small response FIFO.
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shamt,
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryFlag,
    input  logic             alu_zeroFlag,
    input  logic             alu_signFlag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [3:0]       rsp_tag,
    output logic             rsp_error,
    output logic             busy
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_SGT = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd7;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL    = (PTR_W + 1)'(RSP_DEPTH);

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'd4) || (op == 4'd6) || ((op >= 4'd8) && (op <= 4'd10));
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_input1_q, alu_input1_d;
    logic [WIDTH-1:0] alu_input2_q, alu_input2_d;
    logic [4:0]       alu_shamt_q, alu_shamt_d;
    logic [3:0]       tag_q, tag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [WIDTH-1:0] fifo_result [RSP_DEPTH];
    logic [2:0]       fifo_flags  [RSP_DEPTH];
    logic [3:0]       fifo_tag    [RSP_DEPTH];
    logic             fifo_err    [RSP_DEPTH];

    logic             fifo_full, fifo_empty;
    logic             accept, push, pop;
    logic [WIDTH-1:0] push_result;
    logic [2:0]       push_flags;
    logic [3:0]       push_tag;
    logic             push_err;
    logic             cmp_sel;

    logic signed [WIDTH-1:0] cmd_a_s, cmd_b_s;

    assign cmd_a_s    = cmd_a;
    assign cmd_b_s    = cmd_b;
    assign cmp_sel    = (cmd_opcode == OP_SGT) ? (cmd_a_s > cmd_b_s) : (cmd_a_s < cmd_b_s);

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (state_q == ST_IDLE) && !fifo_full;
    assign accept     = cmd_valid && cmd_ready;
    assign pop        = rsp_ready && !fifo_empty;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_input1_d = alu_input1_q;
        alu_input2_d = alu_input2_q;
        alu_shamt_d  = alu_shamt_q;
        tag_d        = tag_q;
        push         = 1'b0;
        push_result  = '0;
        push_flags   = 3'b000;
        push_tag     = cmd_tag;
        push_err     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (is_alu_op(cmd_opcode)) begin
                    alu_opcode_d = cmd_opcode;
                    alu_input1_d = cmd_a;
                    alu_input2_d = cmd_b;
                    alu_shamt_d  = cmd_shamt;
                    cnt_d        = SETTLE_INIT;
                    tag_d        = cmd_tag;
                    state_d      = ST_DRIVE;
                end else if ((cmd_opcode == OP_SGT) || (cmd_opcode == OP_SLT)) begin
                    // Compares are resolved here so the ALU never has to be trusted for them.
                    push        = 1'b1;
                    push_result = {{(WIDTH-1){1'b0}}, cmp_sel};
                    push_flags  = {1'b0, ~cmp_sel, 1'b0};
                end else begin
                    push       = 1'b1;
                    push_flags = 3'b010;
                    push_err   = 1'b1;
                end
            end
        end else begin
            if (cnt_q == 4'd0) begin
                push        = 1'b1;
                push_result = alu_result;
                push_flags  = {alu_carryFlag, alu_zeroFlag, alu_signFlag};
                push_tag    = tag_q;
                push_err    = (alu_opcode_q == OP_DIV) && (alu_input2_q == '0);
                state_d     = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            alu_opcode_q <= 4'd0;
            alu_input1_q <= '0;
            alu_input2_q <= '0;
            alu_shamt_q  <= 5'd0;
            tag_q        <= 4'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_input1_q <= alu_input1_d;
            alu_input2_q <= alu_input2_d;
            alu_shamt_q  <= alu_shamt_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_result[wr_ptr_q] <= push_result;
            fifo_flags[wr_ptr_q]  <= push_flags;
            fifo_tag[wr_ptr_q]    <= push_tag;
            fifo_err[wr_ptr_q]    <= push_err;
        end
    end

    assign rsp_valid      = !fifo_empty;
    assign rsp_result     = fifo_empty ? '0     : fifo_result[rd_ptr_q];
    assign rsp_flags      = fifo_empty ? 3'b000 : fifo_flags[rd_ptr_q];
    assign rsp_tag        = fifo_empty ? 4'd0   : fifo_tag[rd_ptr_q];
    assign rsp_error      = fifo_empty ? 1'b0   : fifo_err[rd_ptr_q];

    assign alu_opcode     = alu_opcode_q;
    assign alu_input1     = alu_input1_q;
    assign alu_input2     = alu_input2_q;
    assign alu_shiftValue = alu_shamt_q;
    assign busy           = (state_q == ST_DRIVE);

endmodule
